redmule_x_feeder: RTL and testbench



---
 rtl/redmule_pkg.sv | 26 ++
 rtl/redmule_x_fifo.sv | 56 +++++
 rtl/redmule_x_feeder.sv | 123 ++++++++++++
 tb/tb_redmule_x_feeder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE X-operand feeder: element formats and status flags.
package redmule_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic busy;
        logic done;
    } x_feeder_flgs_t;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP8:     return 8;
            default: return 16;
        endcase
    endfunction

endpackage

// File: rtl/redmule_x_fifo.sv
// Small power-of-two FIFO holding X beats; pointers carry an extra wrap bit for full/empty.
module redmule_x_fifo #(
    parameter int unsigned DW    = 288,
    parameter int unsigned Depth = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DW-1:0] mem_q [Depth];
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/redmule_x_feeder.sv
// Streams X beats into the X buffer through a FIFO, zero-padding unused elements of a job's last beat.
module redmule_x_feeder
    import redmule_pkg::*;
#(
    parameter int unsigned DW       = 288,
    parameter fp_format_e  FpFormat = FP16,
    parameter int unsigned Depth    = 4,
    localparam int unsigned BITW    = fp_width(FpFormat),
    localparam int unsigned NELEM   = DW / BITW,
    localparam int unsigned LW      = $clog2(NELEM) + 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clear_i,
    input  logic           start_i,
    input  logic [15:0]    n_beats_i,
    input  logic [LW-1:0]  lftovr_i,
    input  logic [DW-1:0]  stream_data_i,
    input  logic           stream_valid_i,
    output logic           stream_ready_o,
    input  logic           buf_full_i,
    output logic           load_o,
    output logic [DW-1:0]  x_data_o,
    output x_feeder_flgs_t flags_o
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic          state_q, state_d;
    logic [15:0]   n_beats_q, n_beats_d;
    logic [LW-1:0] lftovr_q, lftovr_d;
    logic [15:0]   acc_cnt_q, acc_cnt_d;
    logic [15:0]   iss_cnt_q, iss_cnt_d;
    logic          done_q, done_d;

    logic          fifo_full, fifo_empty, accept, last_beat;
    logic [DW-1:0] fifo_head, masked;

    redmule_x_fifo #(
        .DW    (DW),
        .Depth (Depth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (accept),
        .data_i  (stream_data_i),
        .pop_i   (load_o),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign stream_ready_o = (state_q == RUN) && !fifo_full && (acc_cnt_q != n_beats_q);
    assign accept         = stream_valid_i && stream_ready_o;
    assign load_o         = (state_q == RUN) && !fifo_empty && !buf_full_i;
    assign last_beat      = (iss_cnt_q == n_beats_q - 16'd1);

    always_comb begin
        masked = fifo_head;
        if (last_beat && (lftovr_q != '0)) begin
            for (int i = 0; i < NELEM; i++) begin
                if (LW'(i) >= lftovr_q) masked[i*BITW +: BITW] = '0;
            end
        end
    end

    assign x_data_o = load_o ? masked : '0;
    assign flags_o  = {state_q == RUN, done_q};

    always_comb begin
        state_d   = state_q;
        n_beats_d = n_beats_q;
        lftovr_d  = lftovr_q;
        acc_cnt_d = acc_cnt_q;
        iss_cnt_d = iss_cnt_q;
        done_d    = 1'b0;
        if (clear_i) begin
            state_d   = IDLE;
            acc_cnt_d = '0;
            iss_cnt_d = '0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                n_beats_d = n_beats_i;
                lftovr_d  = lftovr_i;
                acc_cnt_d = '0;
                iss_cnt_d = '0;
                // An empty job completes immediately without entering RUN.
                if (n_beats_i == 16'd0) done_d  = 1'b1;
                else                    state_d = RUN;
            end
        end else begin
            if (accept) acc_cnt_d = acc_cnt_q + 16'd1;
            if (load_o) begin
                iss_cnt_d = iss_cnt_q + 16'd1;
                if (last_beat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            n_beats_q <= '0;
            lftovr_q  <= '0;
            acc_cnt_q <= '0;
            iss_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_beats_q <= n_beats_d;
            lftovr_q  <= lftovr_d;
            acc_cnt_q <= acc_cnt_d;
            iss_cnt_q <= iss_cnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_redmule_x_feeder.sv
// Directed scoreboard bench for redmule_x_feeder (DW=288, FP16, Depth=4).
module tb_redmule_x_feeder;
    import redmule_pkg::*;

    localparam int DW    = 288;
    localparam int NELEM = 18;
    localparam int LW    = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clear = 1'b0;
    logic           start = 1'b0;
    logic [15:0]    n_beats = '0;
    logic [LW-1:0]  lftovr = '0;
    logic [DW-1:0]  stream_data = '0;
    logic           stream_valid = 1'b0;
    logic           stream_ready;
    logic           buf_full = 1'b0;
    logic           load;
    logic [DW-1:0]  x_data;
    x_feeder_flgs_t flags;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int job = 1;
    int load_cnt, first_load_cyc, last_load_cyc, loads_when_full, acc_full, start_cyc;
    logic [DW-1:0] last_x;
    logic [DW-1:0] sbq [$];

    redmule_x_feeder #(.DW(DW), .FpFormat(FP16), .Depth(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .start_i        (start),
        .n_beats_i      (n_beats),
        .lftovr_i       (lftovr),
        .stream_data_i  (stream_data),
        .stream_valid_i (stream_valid),
        .stream_ready_o (stream_ready),
        .buf_full_i     (buf_full),
        .load_o         (load),
        .x_data_o       (x_data),
        .flags_o        (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] beat_val(input int j, input int idx, input bit uni);
        logic [DW-1:0] v;
        for (int e = 0; e < NELEM; e++)
            v[e*16 +: 16] = uni ? 16'h3C00 : 16'(j*4096 + idx*256 + e + 1);
        return v;
    endfunction

    function automatic logic [DW-1:0] expect_val(input logic [DW-1:0] v, input int idx, input int n, input int lft);
        logic [DW-1:0] r;
        r = v;
        if (idx == n-1 && lft != 0)
            for (int e = lft; e < NELEM; e++) r[e*16 +: 16] = 16'h0;
        return r;
    endfunction

    // Scoreboard consumer: every load must match the oldest accepted beat.
    always @(negedge clk) begin
        if (rst_n && load) begin
            load_cnt++;
            if (first_load_cyc < 0) first_load_cyc = cyc;
            last_load_cyc = cyc;
            last_x = x_data;
            if (buf_full) loads_when_full++;
            if (sbq.size() == 0) chk("load_without_beat", 1, 0);
            else chk("x_data", x_data, sbq.pop_front());
        end
    end

    task automatic clr_stats();
        load_cnt = 0; first_load_cyc = -1; last_load_cyc = -1; loads_when_full = 0; acc_full = 0;
    endtask

    task automatic feed(input int n, input int lft, input bit uni, input int full_cyc,
                        input int spur, output int done_cyc);
        int idx;
        bit acc;
        idx = 0;
        done_cyc = -1;
        clr_stats();
        @(posedge clk); #1;
        start = 1'b1; n_beats = 16'(n); lftovr = LW'(lft);
        stream_valid = (n > 0); stream_data = beat_val(job, 0, uni); buf_full = (full_cyc > 0);
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        for (int cnt = 0; cnt < 300; cnt++) begin
            @(negedge clk);
            if (flags.done) begin done_cyc = cyc; break; end
            acc = stream_valid && stream_ready;
            if (acc && buf_full) acc_full++;
            @(posedge clk); #1;
            if (cnt == spur) begin start = 1'b1; n_beats = 16'd2; end
            else start = 1'b0;
            if (acc) begin
                sbq.push_back(expect_val(beat_val(job, idx, uni), idx, n, lft));
                idx++;
            end
            stream_valid = (idx < n);
            stream_data  = beat_val(job, idx, uni);
            buf_full     = (cnt + 1 < full_cyc);
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        start = 1'b0; stream_valid = 1'b0; buf_full = 1'b0;
        job++;
    endtask

    initial begin
        int dc, idx;
        bit acc, done_seen;
        logic [DW-1:0] exp_last;

        clr_stats();
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", stream_ready, 0);
        chk("rst_load", load, 0);
        chk("rst_xdata", x_data, 0);
        chk("rst_busy", flags.busy, 0);
        chk("rst_done", flags.done, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", stream_ready, 0);

        // Basic job: three back-to-back loads then a one-cycle done
        feed(3, 0, 0, 0, -1, dc);
        chk("basic_loads", load_cnt, 3);
        chk("basic_consecutive", last_load_cyc - first_load_cyc, 2);
        chk("basic_first_latency", first_load_cyc - start_cyc, 1);
        chk("basic_done_time", dc, last_load_cyc + 1);
        @(negedge clk);
        chk("basic_done_pulse", flags.done, 0);
        chk("basic_busy_after", flags.busy, 0);

        // Leftover masking on the final beat
        feed(2, 5, 1, 0, -1, dc);
        chk("mask_loads", load_cnt, 2);
        exp_last = '0;
        for (int e = 0; e < 5; e++) exp_last[e*16 +: 16] = 16'h3C00;
        chk("mask_last_beat", last_x, exp_last);

        // Backpressure: FIFO fills, nothing issues while the buffer is full
        feed(8, 0, 0, 10, -1, dc);
        chk("bp_accepts_while_full", acc_full, 4);
        chk("bp_loads_while_full", loads_when_full, 0);
        chk("bp_total_loads", load_cnt, 8);

        // Zero-beat job
        feed(0, 0, 0, 0, -1, dc);
        chk("zero_done_time", dc, start_cyc);
        chk("zero_loads", load_cnt, 0);
        @(negedge clk);
        chk("zero_busy", flags.busy, 0);

        // Start during RUN is ignored
        feed(4, 0, 0, 6, 2, dc);
        chk("spur_loads", load_cnt, 4);
        chk("spur_done_time", dc, last_load_cyc + 1);

        // Clear mid-job with two beats issued and two still queued
        clr_stats();
        idx = 0;
        @(posedge clk); #1;
        start = 1'b1; n_beats = 16'd5; lftovr = '0; buf_full = 1'b1;
        stream_valid = 1'b1; stream_data = beat_val(job, 0, 0);
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc = stream_valid && stream_ready;
            @(posedge clk); #1;
            if (acc) begin sbq.push_back(beat_val(job, idx, 0)); idx++; end
            stream_valid = (idx < 4);
            stream_data  = beat_val(job, idx, 0);
        end
        chk("clr_accepted", idx, 4);
        buf_full = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 buf_full = 1'b1;
        chk("clr_issued", load_cnt, 2);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; buf_full = 1'b0;
        sbq.delete();
        job++;
        @(negedge clk);
        chk("clr_busy", flags.busy, 0);
        chk("clr_ready", stream_ready, 0);
        chk("clr_load", load, 0);
        done_seen = flags.done;
        repeat (3) begin
            @(negedge clk);
            done_seen = done_seen | flags.done;
        end
        chk("clr_no_done", done_seen, 0);

        // A fresh job after the clear must see an empty FIFO
        feed(1, 0, 0, 0, -1, dc);
        chk("post_clr_loads", load_cnt, 1);
        chk("post_clr_done_time", dc, last_load_cyc + 1);
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
